// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved at accept time.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready & rdy_in
  // are all high and flush_in is low; valid never drops without a transfer except
  // on flush or reset, and result stays stable while result_valid is held.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             result_valid_q;
  logic [WIDTH-1:0] result_q;

  // Operand decode for the accept cycle
  logic             is_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    is_signed   = ~op[0];
    dvd_neg     = is_signed & dividend[WIDTH-1];
    dvs_neg     = is_signed & divisor[WIDTH-1];
    dvd_abs     = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_abs     = dvs_neg ? (~divisor + 1'b1) : divisor;
    div_zero    = (divisor == '0);
    sgn_ovf     = is_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? dividend : '1;
    end else begin
      special_res = op[1] ? '0 : dividend;
    end
  end

  // One restoring step; |divisor| < 2^WIDTH so the WIDTH+1-bit difference cannot overflow
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] result_d;

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    take     = ~diff[WIDTH];
    rem_d    = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d    = {quo_q[WIDTH-2:0], take};
    quo_fix  = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix  = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
    result_d = op_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      op_q           <= 2'b00;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      quo_neg_q      <= 1'b0;
      rem_neg_q      <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        state_q        <= IDLE;
        cnt_q          <= '0;
        result_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_valid) begin
              op_q  <= op;
              cnt_q <= '0;
              if (div_zero || sgn_ovf) begin
                result_q       <= special_res;
                result_valid_q <= 1'b1;
                state_q        <= DONE;
              end else begin
                rem_q     <= '0;
                quo_q     <= dvd_abs;
                dvs_q     <= dvs_abs;
                quo_neg_q <= dvd_neg ^ dvs_neg;
                rem_neg_q <= dvd_neg;
                state_q   <= CALC;
              end
            end
          end
          CALC: begin
            // The cycle after the last iteration only applies the sign fix
            if (cnt_q == LAST) begin
              result_q       <= result_d;
              result_valid_q <= 1'b1;
              cnt_q          <= '0;
              state_q        <= DONE;
            end else begin
              rem_q <= rem_d;
              quo_q <= quo_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DONE: begin
            if (result_ready) begin
              result_valid_q <= 1'b0;
              state_q        <= IDLE;
            end
          end
          default: begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, random signed/unsigned ops, and
// hand-written flush, backpressure, stall and async-reset sequences.
module tb_seq_divider;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  seq_divider #(.WIDTH(32)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_in     (flush_in),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .dividend     (dividend),
    .divisor      (divisor),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .dbg_state    (dbg_state)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; dividend = a; divisor = b; start_valid = 1'b1;
    @(posedge clk_in); #1;
    start_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until result_valid; optional rdy_in stall window
  task automatic wait_result(input int stall_at, input int stall_len, output int cnt,
                             output logic busy_ok);
    cnt = 0;
    busy_ok = 1'b1;
    while (!result_valid && cnt < 200) begin
      if (start_ready) busy_ok = 1'b0;
      rdy_in = !(cnt >= stall_at && cnt < stall_at + stall_len);
      @(posedge clk_in); #1;
      cnt++;
    end
    rdy_in = 1'b1;
    if (start_ready) busy_ok = 1'b0;
  endtask

  task automatic check_result(input string name);
    logic [31:0] e;
    chk({name, "_valid"}, {31'd0, result_valid}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_result"}, result, e);
    end else begin
      chk({name, "_queue_empty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic consume(input string name);
    result_ready = 1'b1;
    @(posedge clk_in); #1;
    result_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, result_valid}, 32'd0);
    chk({name, "_start_ready"}, {31'd0, start_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat, input string name,
                        input int stall_at, input int stall_len);
    int cnt;
    logic busy_ok;
    exp_q.push_back(e);
    start_op(o, a, b);
    wait_result(stall_at, stall_len, cnt, busy_ok);
    chk({name, "_latency"}, 32'(cnt), 32'(lat));
    chk({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check_result(name);
    consume(name);
  endtask

  initial begin
    int cnt;
    logic busy_ok;
    logic seen;
    logic [31:0] held;
    logic [31:0] a, b, e;
    logic [1:0] o;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33, "divu_100_7"};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33, "remu_100_7"};
    vecs[2]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33, "div_m7_2"};
    vecs[3]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33, "rem_m7_2"};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33, "rem_7_m2"};
    vecs[5]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33, "div_7_m2"};
    vecs[6]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   0,  "divu_x_0"};
    vecs[7]  = '{OP_REM,  32'h1234,       32'd0,          32'h1234,       0,  "rem_x_0"};
    vecs[8]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0,  "div_ovf"};
    vecs[9]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          0,  "rem_ovf"};
    vecs[10] = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33, "div_m100_m7"};
    vecs[11] = '{OP_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   33, "rem_m100_m7"};
    vecs[12] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33, "divu_max_1"};
    vecs[13] = '{OP_REMU, 32'hFFFFFFFF,   32'd10,         32'd5,          33, "remu_max_10"};
    vecs[14] = '{OP_DIVU, 32'd3,          32'd5,          32'd0,          33, "divu_small"};
    vecs[15] = '{OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33, "div_min_2"};
    vecs[16] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33, "divu_no_ovf"};
    vecs[17] = '{OP_DIV,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   0,  "div_x_0"};

    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; start_valid = 1'b0;
    op = 2'b00; dividend = '0; divisor = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 0, 0);
    end

    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = $urandom();
      if (i % 3 == 0) b = b >> $urandom_range(4, 28);
      if (b == 32'd0) b = 32'd1;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) a = 32'd0;
      case (o)
        OP_DIVU: e = a / b;
        OP_REMU: e = a % b;
        OP_DIV:  e = 32'($signed(a) / $signed(b));
        default: e = 32'($signed(a) % $signed(b));
      endcase
      run_op(o, a, b, e, 33, "rand", 0, 0);
    end

    // Backpressure in DONE
    exp_q.push_back(32'd14);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_result(0, 0, cnt, busy_ok);
    held = result;
    seen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #1;
      if (!result_valid || result !== held) seen = 1'b0;
    end
    chk("bp_stable", {31'd0, seen}, 32'd1);
    check_result("bp");
    consume("bp");

    // Flush at cycle 10 of CALC
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk_in);
    #1;
    flush_in = 1'b1;
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    chk("flush_calc_state", {30'd0, dbg_state}, 32'd0);
    chk("flush_calc_start_ready", {31'd0, start_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen = 1'b1;
      @(posedge clk_in); #1;
    end
    chk("flush_calc_no_valid", {31'd0, seen}, 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "after_flush", 0, 0);

    // Flush in the same cycle as the result handshake
    exp_q.push_back(32'd3);
    start_op(OP_DIVU, 32'd9, 32'd3);
    wait_result(0, 0, cnt, busy_ok);
    check_result("flush_done");
    result_ready = 1'b1; flush_in = 1'b1;
    @(posedge clk_in); #1;
    result_ready = 1'b0; flush_in = 1'b0;
    chk("flush_done_valid", {31'd0, result_valid}, 32'd0);
    chk("flush_done_start_ready", {31'd0, start_ready}, 32'd1);
    chk("flush_done_result_kept", result, 32'd3);

    // Flush beats a simultaneous accept
    op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; start_valid = 1'b1; flush_in = 1'b1;
    @(posedge clk_in); #1;
    start_valid = 1'b0; flush_in = 1'b0;
    chk("flush_accept_start_ready", {31'd0, start_ready}, 32'd1);
    chk("flush_accept_state", {30'd0, dbg_state}, 32'd0);

    // rdy_in low for 4 cycles mid-CALC
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 37, "stall", 5, 4);

    // Async reset mid-CALC, observed before the next edge
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("arst_valid", {31'd0, result_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, "after_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
